// File: rtl/conv_pkg.sv
// Shared constants and stream-state encoding for the convolution pixel path
// (pad streamer and 3x3 convolution core).
package conv_pkg;

    localparam int PIXEL_DATAW  = 8;
    localparam int IMAGE_WIDTH  = 512;
    localparam int PADDED_WIDTH = IMAGE_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        TOP    = 3'd1,
        LEFT   = 3'd2,
        BODY   = 3'd3,
        RIGHT  = 3'd4,
        BOTTOM = 3'd5
    } stream_state_t;

endpackage

// File: rtl/conv_pad_streamer_if.sv
// Valid/ready pixel stream bundle: upstream raw pixels in, padded pixels out.
// The master side drives the raw pixels and the downstream ready.
interface conv_pad_streamer_if #(
    parameter int DATAW = conv_pkg::PIXEL_DATAW
);
    logic             i_valid;
    logic [DATAW-1:0] i_x;
    logic             i_last;
    logic             o_ready;
    logic             i_ready;
    logic             o_valid;
    logic [DATAW-1:0] o_x;
    logic             o_frame_done;

    modport master (
        output i_valid, i_x, i_last, i_ready,
        input  o_ready, o_valid, o_x, o_frame_done
    );

    modport slave (
        input  i_valid, i_x, i_last, i_ready,
        output o_ready, o_valid, o_x, o_frame_done
    );
endinterface

// File: rtl/pix_out_reg.sv
// Single-entry output register of the padded stream; refills whenever it is
// empty or being drained, and carries an end-of-frame tag with the pixel.
module pix_out_reg #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DATAW-1:0] load_x,
    input  logic             load_tag,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [DATAW-1:0] o_x,
    output logic             o_tag,
    output logic             can_load
);
    logic             valid_r;
    logic [DATAW-1:0] x_r;
    logic             tag_r;

    assign can_load = !valid_r || i_ready;
    assign o_valid  = valid_r;
    assign o_x      = x_r;
    assign o_tag    = tag_r;

    // Output register: pixel data holds unless a new pixel is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            x_r     <= '0;
            tag_r   <= 1'b0;
        end else if (can_load) begin
            valid_r <= load;
            tag_r   <= load && load_tag;
            if (load) begin
                x_r <= load_x;
            end
        end
    end
endmodule

// File: rtl/conv_pad_streamer.sv
// Zero-pad streamer: surrounds a raw image with one zero row above/below and
// one zero column left/right, producing rows of WIDTH+2 pixels.
module conv_pad_streamer
    import conv_pkg::*;
#(
    parameter int WIDTH = IMAGE_WIDTH,
    parameter int DATAW = PIXEL_DATAW
) (
    input  logic               clk,
    input  logic               reset,
    conv_pad_streamer_if.slave bus
);
    localparam int PAD_W = WIDTH + 2;
    localparam int COL_W = $clog2(PAD_W);
    localparam logic [COL_W-1:0] COL_PAD_LAST  = COL_W'(PAD_W - 1);
    localparam logic [COL_W-1:0] COL_BODY_LAST = COL_W'(WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE       = COL_W'(1);

    stream_state_t    state_r;
    stream_state_t    state_nxt_s;
    logic [COL_W-1:0] col_r;
    logic [COL_W-1:0] col_nxt_s;
    logic             last_row_r;
    logic             last_row_nxt_s;
    logic             load_s;
    logic [DATAW-1:0] load_x_s;
    logic             load_tag_s;
    logic             ready_s;
    logic             can_load_s;
    logic             out_valid_s;
    logic [DATAW-1:0] out_x_s;
    logic             out_tag_s;

    // State, column counter and last-row flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            col_r      <= '0;
            last_row_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            col_r      <= col_nxt_s;
            last_row_r <= last_row_nxt_s;
        end
    end

    // Next-state logic and output-register load selection.
    always_comb begin
        state_nxt_s    = state_r;
        col_nxt_s      = col_r;
        last_row_nxt_s = last_row_r;
        load_s         = 1'b0;
        load_x_s       = '0;
        load_tag_s     = 1'b0;
        ready_s        = 1'b0;
        case (state_r)
            IDLE: begin
                // The pixel that wakes us is left in place; it is consumed in BODY.
                if (bus.i_valid) begin
                    state_nxt_s = TOP;
                    col_nxt_s   = '0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            TOP: begin
                if (can_load_s) begin
                    load_s = 1'b1;
                    if (col_r == COL_PAD_LAST) begin
                        state_nxt_s = LEFT;
                        col_nxt_s   = '0;
                    end else begin
                        col_nxt_s = col_r + COL_ONE;
                    end
                end else begin
                    col_nxt_s = col_r;
                end
            end
            LEFT: begin
                if (can_load_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = BODY;
                    col_nxt_s   = '0;
                end else begin
                    state_nxt_s = LEFT;
                end
            end
            BODY: begin
                ready_s = can_load_s;
                if (bus.i_valid && can_load_s) begin
                    load_s   = 1'b1;
                    load_x_s = bus.i_x;
                    if (col_r == COL_BODY_LAST) begin
                        state_nxt_s    = RIGHT;
                        col_nxt_s      = '0;
                        last_row_nxt_s = bus.i_last;
                    end else begin
                        col_nxt_s = col_r + COL_ONE;
                    end
                end else begin
                    col_nxt_s = col_r;
                end
            end
            RIGHT: begin
                if (can_load_s) begin
                    load_s      = 1'b1;
                    col_nxt_s   = '0;
                    state_nxt_s = last_row_r ? BOTTOM : LEFT;
                end else begin
                    state_nxt_s = RIGHT;
                end
            end
            BOTTOM: begin
                if (can_load_s) begin
                    load_s = 1'b1;
                    if (col_r == COL_PAD_LAST) begin
                        load_tag_s     = 1'b1;
                        state_nxt_s    = IDLE;
                        col_nxt_s      = '0;
                        last_row_nxt_s = 1'b0;
                    end else begin
                        col_nxt_s = col_r + COL_ONE;
                    end
                end else begin
                    col_nxt_s = col_r;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                col_nxt_s      = '0;
                last_row_nxt_s = 1'b0;
            end
        endcase
    end

    pix_out_reg #(.DATAW(DATAW)) u_pix_out_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_x   (load_x_s),
        .load_tag (load_tag_s),
        .i_ready  (bus.i_ready),
        .o_valid  (out_valid_s),
        .o_x      (out_x_s),
        .o_tag    (out_tag_s),
        .can_load (can_load_s)
    );

    // Ready chains combinationally from downstream, as the core expects.
    assign bus.o_ready      = !reset && ready_s;
    assign bus.o_valid      = out_valid_s;
    assign bus.o_x          = out_x_s;
    assign bus.o_frame_done = out_tag_s && bus.i_ready;
endmodule
